// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen RTL library.
// Holds the edge-selection enum and the counter width function used by the event capture block.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_RISING_EDGE,
        RGGEN_FALLING_EDGE,
        RGGEN_BOTH_EDGE
    } rggen_edge_mode;

    // Counter widths never collapse to zero bits, even when only one state is needed.
    function automatic int rggen_clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rggen_event_filter.sv
// Single event bit: synchronizer chain, debounce filter and edge detector.
// o_rise/o_fall are asserted in the cycle in which the filtered level is about to change.
module rggen_event_filter
    import rggen_rtl_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic INITIAL_LEVEL   = 1'b0
)(
    input  logic clk,
    input  logic rst,
    input  logic i_event,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_WIDTH = rggen_clog2_min1(DEBOUNCE_CYCLES + 1);

    logic sync;
    logic level;
    logic change;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign sync = i_event;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_ff;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_ff <= {SYNC_STAGES{INITIAL_LEVEL}};
            end else begin
                sync_ff[0] <= i_event;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_ff[i] <= sync_ff[i-1];
                end
            end
        end

        assign sync = sync_ff[SYNC_STAGES-1];
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
        assign change = (sync != level);
    end else begin : g_debounce
        localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

        logic [CNT_WIDTH-1:0] cnt;

        // Any cycle of agreement restarts the count, so short glitches never accumulate.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if ((sync == level) || (cnt == CNT_LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign change = (sync != level) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= INITIAL_LEVEL;
        end else if (change) begin
            level <= sync;
        end
    end

    assign o_level = level;
    assign o_rise  = change & sync;
    assign o_fall  = change & ~sync;

endmodule

// File: rtl/rggen_event_capture.sv
// Turns raw, possibly bouncing event lines into one-cycle set/clear pulses for a status field.
// Each bit is filtered independently; enable gating and overflow flagging happen here.
module rggen_event_capture
    import rggen_rtl_pkg::*;
#(
    parameter int                 WIDTH           = 1,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 0,
    parameter rggen_edge_mode     EDGE_MODE       = RGGEN_RISING_EDGE,
    parameter logic [WIDTH-1:0]   INITIAL_LEVEL   = '0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_event,
    input  logic [WIDTH-1:0] i_enable,
    input  logic [WIDTH-1:0] i_status,
    output logic [WIDTH-1:0] o_set_or_clear,
    output logic [WIDTH-1:0] o_overflow,
    output logic [WIDTH-1:0] o_level
);

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rggen_event_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INITIAL_LEVEL   (INITIAL_LEVEL[i])
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .i_event (i_event[i]),
            .o_level (o_level[i]),
            .o_rise  (rise[i]),
            .o_fall  (fall[i])
        );
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            RGGEN_RISING_EDGE:  edge_hit = rise;
            RGGEN_FALLING_EDGE: edge_hit = fall;
            default:            edge_hit = rise | fall;
        endcase
    end

    // Edges seen while disabled are dropped for good; the filter state keeps tracking regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_set_or_clear <= '0;
            o_overflow     <= '0;
        end else begin
            o_set_or_clear <= edge_hit & i_enable;
            o_overflow     <= edge_hit & i_enable & i_status;
        end
    end

endmodule
